pulse_chan_regs: RTL
====================

// Module: pulse_chan_regs
// PURPOSE
//  CPU-side register front-end for one pulse sound channel (NRx0..NRx4). Accepts
//  byte writes/reads from the APU bus and produces the control fields consumed by the
//  channel datapath: length load/enable and trigger for the length counter, plus the
//  sweep, duty, envelope and frequency fields. Sits between the APU bus decoder and
//  the per-channel length counter, sweep, envelope and duty units.
// PARAMETERS
//  LEN_BITS   6  width of length-load field (6 = pulse channels; 8 = wave channel)
//  HAS_SWEEP  1  1 = NRx0 sweep register present (ch1); 0 = absent (ch2)
// PORTS
//  clk             in   1         system clock (4 MHz domain)
//  rst_n           in   1         asynchronous, active-low reset
//  bus_addr        in   3         register offset: 0=NRx0 .. 4=NRx4, 5-7 unmapped
//  bus_wdata       in   8         write data
//  bus_wr          in   1         write strobe, one cycle per access
//  bus_rd          in   1         read strobe, one cycle per access
//  bus_rdata       out  8         read data, valid while bus_rvalid=1
//  bus_rvalid      out  1         read-data valid pulse
//  apu_power       in   1         NR52 bit 7; 0 = APU powered off
//  sweep_period    out  3         NRx0[6:4]
//  sweep_negate    out  1         NRx0[3]
//  sweep_shift     out  3         NRx0[2:0]
//  duty            out  2         NRx1[7:6]
//  len_load        out  LEN_BITS  NRx1[LEN_BITS-1:0]
//  len_load_strobe out  1         one-cycle pulse: NRx1 written
//  env_init_vol    out  4         NRx2[7:4]
//  env_dir         out  1         NRx2[3]
//  env_period      out  3         NRx2[2:0]
//  dac_enable      out  1         NRx2[7:3] != 0
//  freq            out  11        {NRx4[2:0], NRx3[7:0]}
//  len_enable      out  1         NRx4[6]
//  trigger         out  1         one-cycle pulse: NRx4 written with bit 7 set
// BEHAVIOUR
//  - Reset: all stored fields 0; every output 0 (incl. bus_rdata, bus_rvalid, strobes).
//  - Write (bus_wr=1, apu_power=1): addressed register updates at the clock edge;
//    updated fields visible on outputs the next cycle. Writes to 5-7 ignored.
//    HAS_SWEEP=0: writes to offset 0 ignored, sweep outputs held 0.
//  - len_load_strobe: high exactly one cycle, coincident with the new len_load value.
//  - trigger: high exactly one cycle after an NRx4 write with wdata[7]=1, coincident
//    with updated len_enable/freq[10:8]; suppressed (stays 0) if dac_enable=0 at that
//    point. Bit 7 itself is not stored. Back-to-back NRx4 writes -> back-to-back pulses.
//  - Read: bus_rvalid pulses the cycle after bus_rd; bus_rdata = stored value OR mask:
//    NRx0 0x80 (0xFF if HAS_SWEEP=0), NRx1 0x3F, NRx2 0x00, NRx3 0xFF, NRx4 0xBF,
//    unmapped 0xFF. bus_rdata holds its value until the next read.
//  - Read and write same cycle, same register: read returns the pre-write value.
//  - Power-off: while apu_power=0, all stored fields forced to 0 each cycle, writes
//    ignored, no strobes; reads still answered (return masks only). Power-on resumes
//    from zeroed state; no trigger generated by power transitions.
//  - rst_n assertion mid-access: strobes and bus_rvalid drop immediately; no pending
//    read or trigger survives reset release.
//  - Read latency 1 cycle; no back-pressure; one access per cycle.
// TESTING
//  - Reset, then read offsets 0-7 -> 80,3F,00,FF,BF,FF,FF,FF, each rvalid 1 cycle later.
//  - Write NRx1=0xC5 -> duty=3, len_load=0x05, len_load_strobe high exactly 1 cycle;
//    readback 0xFF.
//  - NRx2=0xF3 then NRx4=0xC7 -> trigger 1 cycle, len_enable=1, freq[10:8]=7;
//    readback NRx4=0xFF. Repeat with NRx2=0x00 -> no trigger, len_enable still 1.
//  - NRx3=0xAB with simultaneous read of NRx3 -> rdata 0xFF; next read 0xFF; freq=0x7AB.
//  - apu_power=0, write NRx2=0xF0 -> ignored, dac_enable=0; earlier fields read as 0.
//  - HAS_SWEEP=0 build: write NRx0=0x7F -> sweep outputs 0, readback 0xFF.

Source files
------------

// File: rtl/pulse_chan_regs.sv
// CPU-side register front-end for one pulse channel (NRx0..NRx4): stores the
// channel fields, answers masked reads and emits length-load and trigger pulses.
module pulse_chan_regs #(
  parameter int LEN_BITS  = 6,
  parameter bit HAS_SWEEP = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          bus_addr,
  input  logic [7:0]          bus_wdata,
  input  logic                bus_wr,
  input  logic                bus_rd,
  output logic [7:0]          bus_rdata,
  output logic                bus_rvalid,
  input  logic                apu_power,
  output logic [2:0]          sweep_period,
  output logic                sweep_negate,
  output logic [2:0]          sweep_shift,
  output logic [1:0]          duty,
  output logic [LEN_BITS-1:0] len_load,
  output logic                len_load_strobe,
  output logic [3:0]          env_init_vol,
  output logic                env_dir,
  output logic [2:0]          env_period,
  output logic                dac_enable,
  output logic [10:0]         freq,
  output logic                len_enable,
  output logic                trigger
);

  logic [6:0] nr0_q, nr0_d;
  logic [7:0] nr1_q, nr1_d;
  logic [7:0] nr2_q, nr2_d;
  logic [7:0] nr3_q, nr3_d;
  logic       len_en_q, len_en_d;
  logic [2:0] freq_hi_q, freq_hi_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q;
  logic       len_strobe_q, len_strobe_d;
  logic       trigger_q, trigger_d;
  logic       wr_en;

  assign wr_en = bus_wr && apu_power;

  always_comb begin
    nr0_d     = nr0_q;
    nr1_d     = nr1_q;
    nr2_d     = nr2_q;
    nr3_d     = nr3_q;
    len_en_d  = len_en_q;
    freq_hi_d = freq_hi_q;
    if (!apu_power) begin
      nr0_d     = '0;
      nr1_d     = '0;
      nr2_d     = '0;
      nr3_d     = '0;
      len_en_d  = 1'b0;
      freq_hi_d = '0;
    end else if (bus_wr) begin
      case (bus_addr)
        3'd0: if (HAS_SWEEP) nr0_d = bus_wdata[6:0];
        3'd1: nr1_d = bus_wdata;
        3'd2: nr2_d = bus_wdata;
        3'd3: nr3_d = bus_wdata;
        3'd4: begin
          len_en_d  = bus_wdata[6];
          freq_hi_d = bus_wdata[2:0];
        end
        default: ;
      endcase
    end
  end

  // Trigger is gated by the DAC state in force when the NRx4 write lands.
  assign len_strobe_d = wr_en && (bus_addr == 3'd1);
  assign trigger_d    = wr_en && (bus_addr == 3'd4) && bus_wdata[7] && (nr2_q[7:3] != 5'd0);

  // Reads see the registers before any same-cycle write; unused bits read as 1.
  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      case (bus_addr)
        3'd0:    rdata_d = HAS_SWEEP ? {1'b1, nr0_q} : 8'hFF;
        3'd1:    rdata_d = nr1_q | 8'h3F;
        3'd2:    rdata_d = nr2_q;
        3'd3:    rdata_d = 8'hFF;
        3'd4:    rdata_d = {1'b1, len_en_q, 6'h3F};
        default: rdata_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nr0_q        <= '0;
      nr1_q        <= '0;
      nr2_q        <= '0;
      nr3_q        <= '0;
      len_en_q     <= 1'b0;
      freq_hi_q    <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      len_strobe_q <= 1'b0;
      trigger_q    <= 1'b0;
    end else begin
      nr0_q        <= nr0_d;
      nr1_q        <= nr1_d;
      nr2_q        <= nr2_d;
      nr3_q        <= nr3_d;
      len_en_q     <= len_en_d;
      freq_hi_q    <= freq_hi_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= bus_rd;
      len_strobe_q <= len_strobe_d;
      trigger_q    <= trigger_d;
    end
  end

  assign bus_rdata       = rdata_q;
  assign bus_rvalid      = rvalid_q;
  assign sweep_period    = nr0_q[6:4];
  assign sweep_negate    = nr0_q[3];
  assign sweep_shift     = nr0_q[2:0];
  assign duty            = nr1_q[7:6];
  assign len_load        = nr1_q[LEN_BITS-1:0];
  assign len_load_strobe = len_strobe_q;
  assign env_init_vol    = nr2_q[7:4];
  assign env_dir         = nr2_q[3];
  assign env_period      = nr2_q[2:0];
  assign dac_enable      = nr2_q[7:3] != 5'd0;
  assign freq            = {freq_hi_q, nr3_q};
  assign len_enable      = len_en_q;
  assign trigger         = trigger_q;

endmodule
